// File: rtl/f_alu_sched_pkg.sv
// Shared definitions for the f_alu request scheduler: opcodes, FSM states,
// default latencies and the opcode-to-latency mapping.
package f_alu_sched_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int LAT_LONG_DEF = 8;
  localparam int LAT_FMA_DEF  = 2;

  localparam logic [5:0] OP_FADD   = 6'h00;
  localparam logic [5:0] OP_FSUB   = 6'h01;
  localparam logic [5:0] OP_FMUL   = 6'h02;
  localparam logic [5:0] OP_FDIV   = 6'h03;
  localparam logic [5:0] OP_FSQRT  = 6'h04;
  localparam logic [5:0] OP_FMADD  = 6'h05;
  localparam logic [5:0] OP_FMSUB  = 6'h06;
  localparam logic [5:0] OP_FNMADD = 6'h07;
  localparam logic [5:0] OP_FNMSUB = 6'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Unknown opcodes fall through to a single EXEC cycle.
  function automatic int op_latency(input logic [5:0] op, input int lat_long,
                                    input int lat_fma);
    int lat;
    lat = 1;
    if (op == OP_FDIV || op == OP_FSQRT) begin
      lat = lat_long;
    end else if (op == OP_FMADD || op == OP_FMSUB ||
                 op == OP_FNMADD || op == OP_FNMSUB) begin
      lat = lat_fma;
    end
    return lat;
  endfunction

endpackage

// File: rtl/f_alu_sched_if.sv
// Requester and f_alu signal bundle for the scheduler; slave = scheduler side.
interface f_alu_sched_if #(
  parameter int NREQ = 4
);
  // Handshake: requester i holds req_valid[i] with stable operands; the op is
  // taken in the cycle req_ready[i] is high together with req_valid[i].
  // resp_valid is a one-cycle pulse with no backpressure.
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_data1;
  logic [NREQ*32-1:0] req_data2;
  logic [NREQ*32-1:0] req_data3;
  logic [NREQ*6-1:0]  req_select;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_result;
  logic [31:0]        alu_data1;
  logic [31:0]        alu_data2;
  logic [31:0]        alu_data3;
  logic [5:0]         alu_select;
  logic [31:0]        alu_result;
  logic               busy;

  modport master (
    output req_valid, req_data1, req_data2, req_data3, req_select, alu_result,
    input  req_ready, resp_valid, resp_result, alu_data1, alu_data2, alu_data3,
           alu_select, busy
  );

  modport slave (
    input  req_valid, req_data1, req_data2, req_data3, req_select, alu_result,
    output req_ready, resp_valid, resp_result, alu_data1, alu_data2, alu_data3,
           alu_select, busy
  );
endinterface

// File: rtl/f_alu_sched_rr_arbiter.sv
// Round-robin grant: lowest requesting index at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic found;

  // First pass covers ptr..NREQ-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/f_alu_sched.sv
// Shares one external f_alu among NREQ requesters: round-robin accept,
// fixed per-opcode execute latency, registered result with a one-hot pulse.
module f_alu_sched
  import f_alu_sched_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int LAT_LONG = LAT_LONG_DEF,
  parameter int LAT_FMA  = LAT_FMA_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  f_alu_sched_if.slave bus,
  output state_t      dbg_state
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXL = (LAT_LONG > LAT_FMA) ? LAT_LONG : LAT_FMA;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL + 1) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, g_q, gidx;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant;
  logic            accept, capture;
  logic [5:0]      sel_g;
  logic [31:0]     d1_g, d2_g, d3_g;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req  (bus.req_valid),
    .ptr  (ptr),
    .grant(grant)
  );

  always_comb begin
    gidx  = '0;
    sel_g = '0;
    d1_g  = '0;
    d2_g  = '0;
    d3_g  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx  = PW'(i);
        sel_g = bus.req_select[i*6 +: 6];
        d1_g  = bus.req_data1[i*32 +: 32];
        d2_g  = bus.req_data2[i*32 +: 32];
        d3_g  = bus.req_data3[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Ready is masked by resetn so nothing looks accepted while reset is held.
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    capture        = 1'b0;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    case (state)
      ST_IDLE: begin
        if (|grant) begin
          bus.req_ready = grant & {NREQ{resetn}};
          accept        = 1'b1;
          state_nxt     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == CW'(1)) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.resp_valid = NREQ'(1) << g_q;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr             <= '0;
      g_q             <= '0;
      cnt             <= '0;
      bus.alu_data1   <= '0;
      bus.alu_data2   <= '0;
      bus.alu_data3   <= '0;
      bus.alu_select  <= '0;
      bus.resp_result <= '0;
    end else if (accept) begin
      ptr            <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
      g_q            <= gidx;
      cnt            <= CW'(op_latency(sel_g, LAT_LONG, LAT_FMA));
      bus.alu_data1  <= d1_g;
      bus.alu_data2  <= d2_g;
      bus.alu_data3  <= d3_g;
      bus.alu_select <= sel_g;
    end else if (state == ST_EXEC) begin
      cnt <= cnt - CW'(1);
      if (capture) bus.resp_result <= bus.alu_result;
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_f_alu_sched.sv
// Directed bench for f_alu_sched with a behavioural f_alu and a response scoreboard.
module tb_f_alu_sched;
  import f_alu_sched_pkg::*;

  localparam int NREQ     = 4;
  localparam int LAT_LONG = 8;
  localparam int LAT_FMA  = 2;
  localparam int SB_W     = 66;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F6 = 32'h40C00000;
  localparam logic [31:0] F7 = 32'h40E00000;

  logic   clk = 1'b0;
  logic   resetn;
  state_t dbg_state;
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     last;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] sb_e;

  logic [NREQ-1:0][31:0] d1, d2, d3;
  logic [NREQ-1:0][5:0]  sel;

  f_alu_sched_if #(.NREQ(NREQ)) bus ();

  f_alu_sched #(.NREQ(NREQ), .LAT_LONG(LAT_LONG), .LAT_FMA(LAT_FMA)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  assign bus.req_data1  = d1;
  assign bus.req_data2  = d2;
  assign bus.req_data3  = d3;
  assign bus.req_select = sel;

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- f_alu model ----------------
  function automatic real sp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'h0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] falu(input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] c);
    real x, y, z;
    x = sp2r(a);
    y = sp2r(b);
    z = sp2r(c);
    case (op)
      OP_FADD:   return r2sp(x + y);
      OP_FSUB:   return r2sp(x - y);
      OP_FMUL:   return r2sp(x * y);
      OP_FDIV:   return r2sp(x / y);
      OP_FSQRT:  return r2sp($sqrt(x));
      OP_FMADD:  return r2sp(x * y + z);
      OP_FMSUB:  return r2sp(x * y - z);
      OP_FNMADD: return r2sp(-(x * y + z));
      OP_FNMSUB: return r2sp(-(x * y - z));
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] op);
    if (op == OP_FDIV || op == OP_FSQRT) return LAT_LONG;
    if (op inside {OP_FMADD, OP_FMSUB, OP_FNMADD, OP_FNMSUB}) return LAT_FMA;
    return 1;
  endfunction

  always_comb bus.alu_result = falu(bus.alu_select, bus.alu_data1, bus.alu_data2,
                                    bus.alu_data3);

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] i, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
    sel[i] = op;
    d1[i]  = a;
    d2[i]  = b;
    d3[i]  = c;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic drop(input logic [1:0] i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {requester id, expected result, cycle of the expected pulse}.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_ready[2'(k)] && bus.req_valid[2'(k)])
          exp_q.push_back({2'(k), falu(sel[2'(k)], d1[2'(k)], d2[2'(k)], d3[2'(k)]),
                           32'(cyc + lat_of(sel[2'(k)]) + 1)});
      end
      if (bus.resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'(bus.resp_valid), 32'h0);
        end else begin
          sb_e = exp_q.pop_front();
          check("resp_id", 32'(bus.resp_valid), 32'(1) << sb_e[65:64]);
          check("resp_result", bus.resp_result, sb_e[63:32]);
          check("resp_cycle", 32'(cyc), sb_e[31:0]);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0;
    d1 = '0; d2 = '0; d3 = '0; sel = '0;
    bus.req_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_alu_d1", bus.alu_data1, 32'h0);
    check("rst_alu_sel", 32'(bus.alu_select), 32'h0);
    check("rst_result", bus.resp_result, 32'h0);
    bus.req_valid = '0;
    @(posedge clk); #1 resetn = 1'b1;

    // single FADD on req0
    @(posedge clk); #1 drive(2'd0, OP_FADD, F1, F2, 32'h0);
    #1 check("fadd_ready_T", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1 drop(2'd0);
    @(negedge clk);
    check("fadd_busy_T1", 32'(bus.busy), 32'h1);
    check("fadd_alu_sel", 32'(bus.alu_select), 32'(OP_FADD));
    check("fadd_alu_d2", bus.alu_data2, F2);
    @(negedge clk);
    check("fadd_resp_T2", 32'(bus.resp_valid), 32'h1);
    check("fadd_result", bus.resp_result, F3);
    check("fadd_busy_T2", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("fadd_idle_T3", 32'(bus.busy), 32'h0);

    // FDIV on req2; req0 raised during EXEC must be ignored
    @(posedge clk); #1 drive(2'd2, OP_FDIV, F6, F2, 32'h0);
    #1 check("fdiv_ready_T", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1 drop(2'd2); drive(2'd0, OP_FADD, F2, F2, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("fdiv_ready_T%0d", k), 32'(bus.req_ready), 32'h0);
      check($sformatf("fdiv_resp_T%0d", k), 32'(bus.resp_valid), (k == 9) ? 32'h4 : 32'h0);
    end
    check("fdiv_result", bus.resp_result, F3);
    @(posedge clk); #1 drop(2'd0);
    @(negedge clk);
    check("fdiv_idle", 32'(bus.busy), 32'h0);

    // wrap-around from ptr=3 with req1 and req3 pending
    @(posedge clk); #1 drive(2'd1, OP_FADD, F1, F1, 32'h0); drive(2'd3, OP_FADD, F2, F1, 32'h0);
    #1 check("wrap_grant3", 32'(bus.req_ready), 32'h8);
    @(posedge clk); #1 drop(2'd3);
    repeat (3) @(negedge clk);
    check("wrap_grant1", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1 drop(2'd1);
    repeat (3) @(negedge clk);
    check("wrap_idle", 32'(bus.busy), 32'h0);

    // contention after reset: all four valid continuously
    @(posedge clk); #1 resetn = 1'b0;
    drive(2'd0, OP_FADD, F1, F2, 32'h0);
    drive(2'd1, OP_FSUB, F6, F1, 32'h0);
    drive(2'd2, OP_FMUL, F2, F3, 32'h0);
    drive(2'd3, OP_FADD, F3, F3, 32'h0);
    @(posedge clk); #1 resetn = 1'b1;
    last = 0;
    for (int n = 0; n < 5; n++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (bus.req_ready == '0 && w < 10) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("cont_grant_%0d", n), 32'(bus.req_ready), 32'(1) << (n % 4));
      if (n > 0) check($sformatf("cont_gap_%0d", n), 32'(cyc - last), 32'd3);
      last = cyc;
    end
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (3) @(negedge clk);
    check("cont_idle", 32'(bus.busy), 32'h0);

    // reset in the middle of an FDIV on req1
    @(posedge clk); #1 drive(2'd1, OP_FDIV, F6, F3, 32'h0);
    #1 check("abort_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1 drop(2'd1);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_alu_d1", bus.alu_data1, 32'h0);
    check("abort_alu_sel", 32'(bus.alu_select), 32'h0);
    check("abort_result", bus.resp_result, 32'h0);
    @(posedge clk); #1 resetn = 1'b1;
    drive(2'd0, OP_FADD, F1, F1, 32'h0); drive(2'd3, OP_FADD, F1, F2, 32'h0);
    #1 check("post_abort_grant0", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1 drop(2'd0); drop(2'd3);
    repeat (3) @(negedge clk);
    check("post_abort_idle", 32'(bus.busy), 32'h0);

    // FMADD on req1; operand change after acceptance must not reach the ALU
    @(posedge clk); #1 drive(2'd1, OP_FMADD, F2, F3, F1);
    #1 check("fma_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1 drop(2'd1); d1[1] = 32'hDEADBEEF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("fma_alu_hold_T%0d", k), bus.alu_data1, F2);
      check($sformatf("fma_resp_T%0d", k), 32'(bus.resp_valid), (k == 3) ? 32'h2 : 32'h0);
    end
    check("fma_result", bus.resp_result, F7);
    @(negedge clk);
    check("fma_idle", 32'(bus.busy), 32'h0);
    check("result_hold", bus.resp_result, F7);

    // unknown opcode on req2: one EXEC cycle, f_alu returns 0
    @(posedge clk); #1 drive(2'd2, 6'h3F, F6, F6, F6);
    #1 check("unk_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1 drop(2'd2);
    @(negedge clk);
    check("unk_alu_sel", 32'(bus.alu_select), 32'h3F);
    @(negedge clk);
    check("unk_resp", 32'(bus.resp_valid), 32'h4);
    check("unk_result", bus.resp_result, 32'h0);
    @(negedge clk);
    check("unk_idle", 32'(bus.busy), 32'h0);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/f_alu_sched.md
F_ALU_SCHED -- requirements
Module: f_alu_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one f_alu.
REQ-002 The block SHALL have parameter LAT_LONG, default 8, EXEC cycles for FDIV/FSQRT.
REQ-003 The block SHALL have parameter LAT_FMA, default 2, EXEC cycles for FMADD/FMSUB/FNMADD/FNMSUB.
REQ-004 The block SHALL have port CLK  in  1  the single clock; all state changes on rising edge.
REQ-005 The block SHALL have port RESETN  in  1  reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port REQ_VALID  in  NREQ  per-requester operation request.
REQ-007 The block SHALL have port REQ_READY  out  NREQ  per-requester acceptance, one-hot or zero.
REQ-008 The block SHALL have ports REQ_DATA1, REQ_DATA2, REQ_DATA3  in  NREQ*32 each  flattened operands; requester i occupies bits [32i+31:32i].
REQ-009 The block SHALL have port REQ_SELECT  in  NREQ*6  flattened 6-bit f_alu opcodes.
REQ-010 The block SHALL have port RESP_VALID  out  NREQ  one-cycle completion pulse, one-hot or zero.
REQ-011 The block SHALL have port RESP_RESULT  out  32  registered result, shared by all requesters.
REQ-012 The block SHALL have ports ALU_DATA1, ALU_DATA2, ALU_DATA3  out  32 each, and ALU_SELECT  out  6, all driving f_alu.
REQ-013 The block SHALL have port ALU_RESULT  in  32  f_alu RESULT.
REQ-014 The block SHALL have port BUSY  out  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-016 In IDLE with any REQ_VALID high, REQ_READY SHALL assert combinationally for exactly one granted requester, and that cycle is the acceptance cycle T.
REQ-017 Grant SHALL be round-robin: the lowest index at or above pointer PTR (wrapping modulo NREQ) with REQ_VALID high wins.
REQ-018 After each grant g, PTR SHALL be set to (g+1) mod NREQ.
REQ-019 At T the block SHALL register the granted operands and opcode onto ALU_* and record g.
REQ-020 At T the cycle counter SHALL load L: LAT_LONG for OP_FDIV/OP_FSQRT, LAT_FMA for fused ops, 1 otherwise.
REQ-021 The FSM SHALL go to EXEC at T+1 and occupy cycles T+1..T+L, decrementing the counter each cycle.
REQ-022 ALU_* outputs SHALL remain stable from T+1 until leaving DONE.
REQ-023 In the last EXEC cycle (T+L), ALU_RESULT SHALL be captured into RESP_RESULT.
REQ-024 DONE SHALL occupy cycle T+L+1 with RESP_VALID[g]=1 and all other RESP_VALID bits 0; it then goes to IDLE at T+L+2.
REQ-025 RESP_RESULT SHALL hold its value until the next capture.
REQ-026 REQ_VALID SHALL be ignored outside IDLE, and REQ_READY SHALL be 0 in EXEC and DONE.
REQ-027 A requester dropping REQ_VALID before grant SHALL lose no state and be given no grant.
REQ-028 Responses SHALL have no backpressure, and exactly one RESP_VALID pulse SHALL follow each acceptance.
REQ-029 Minimum spacing between acceptances SHALL be L+2 cycles.
REQ-030 An unknown opcode SHALL be forwarded unchanged with L=1; the f_alu then returns 0.

Reset
REQ-031 On RESETN low, the block SHALL immediately go to IDLE.
REQ-032 On RESETN low, PTR, the counter, ALU_DATA1/2/3, ALU_SELECT and RESP_RESULT SHALL be 0.
REQ-033 On RESETN low, REQ_READY, RESP_VALID and BUSY SHALL be 0.
REQ-034 Reset during EXEC or DONE SHALL abort the operation with no RESP_VALID pulse, and PTR SHALL return to 0.

Structure
REQ-035 The shared package SHALL hold opcode constants OP_FDIV, OP_FSQRT, OP_FMADD, OP_FMSUB, OP_FNMADD and OP_FNMSUB, shared with f_alu.
REQ-036 The shared package SHALL hold the state encodings and the default latency constants.
REQ-037 The round-robin grant logic SHALL be a sub-module rr_arbiter with inputs REQ and PTR and a one-hot GRANT output.
REQ-038 f_alu SHALL be instantiated outside this block.

Verification
REQ-039 Single FADD: req0 valid with 1.0+2.0 at T -> READY[0] at T, BUSY T+1..T+2, RESP_VALID[0] at T+2, RESP_RESULT=0x40400000.
REQ-040 FDIV with LAT_LONG=8: req2 issues 6.0/2.0 -> RESP_VALID[2] exactly at T+9, result 0x40400000, READY all 0 during T+1..T+9.
REQ-041 Contention: all 4 requesters valid continuously after reset, 1-cycle ops -> grant order 0,1,2,3,0 with accepts every 3 cycles.
REQ-042 Wrap-around: PTR=3, only req1 and req3 valid -> req3 granted and PTR becomes 0; next grant goes to req1.
REQ-043 Reset mid-op: RESETN low at T+4 of an FDIV -> no RESP_VALID pulse, all outputs 0, and the next grant after release goes to req0.
REQ-044 Fused op: FMADD 2.0*3.0+1.0 -> RESP_VALID at T+3 with RESP_RESULT=0x40E00000.
